branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Pipelined branch/jump resolution unit for the EX stage, parametrised in XLEN and predictor depth.
- Evaluates RV32/64 conditional branches, JAL and JALR, computes the target and link address, and checks the result against the fetch-stage prediction.
- One registered output stage with valid/ready handshake.
- Contains a BHT of 2-bit saturating counters: read by fetch, trained on every accepted conditional branch.

Parameters:
XLEN, 32, operand/PC width (32 or 64)
BHT_ENTRIES, 64, number of 2-bit counters; power of two, >=2
BHT_IDX, $clog2(BHT_ENTRIES), derived, not overridable

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  drop the output-stage contents this cycle
in_valid  in  1  request valid
in_ready  out  1  unit can accept
in_is_branch  in  1  conditional branch
in_is_jal  in  1  JAL
in_is_jalr  in  1  JALR
in_funct3  in  3  branch condition
in_pc  in  XLEN  instruction PC
in_rs1  in  XLEN  operand 1
in_rs2  in  XLEN  operand 2
in_imm  in  XLEN  sign-extended immediate
in_pred_taken  in  1  fetch prediction
in_pred_target  in  XLEN  fetch-predicted target
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
out_taken  out  1  resolved direction
out_target  out  XLEN  resolved target
out_link  out  XLEN  pc+4
out_mispredict  out  1  redirect required
out_redirect_pc  out  XLEN  correct next PC
out_misalign  out  1  taken target not 4-byte aligned
bht_pc  in  XLEN  fetch lookup PC
bht_taken  out  1  predicted direction (counter MSB)

Behaviour:
- Reset (async, rst_n=0): out_valid=0; all data outputs=0; every BHT counter=2'b01 (weakly not-taken). in_ready=1 once rst_n deasserts.
- Handshake: in_ready = !out_valid || out_ready. Accept on in_valid&&in_ready. Results appear on out_valid the next cycle (latency 1). Back-to-back accept is allowed when out_ready=1.
- Output hold: while out_valid && !out_ready, all out_* are held stable.
- flush: out_valid clears next cycle, even if an accept happens in the same cycle (flush wins). BHT training for that accepted branch still occurs.
- Flags:
  - Exactly one of is_branch/is_jal/is_jalr is set, or none.
  - None set: taken=0, mispredict=0, redirect_pc=pc+4.
- Direction:
  - JAL/JALR: taken=1.
  - Branch, by funct3: 000 EQ; 001 NE; 100 signed LT; 101 signed GE; 110 unsigned LTU; 111 unsigned GEU; 010/011 not-taken.
- Target: branch/JAL = pc+imm; JALR = (rs1+imm) & ~1. All arithmetic is modulo 2^XLEN. link = pc+4, with wrap-around.
- Mispredict = (taken != pred_taken) || (taken && target != pred_target).
- redirect_pc = taken ? target : pc+4.
- misalign = taken && target[1] (bit 0 already clear or ignored); mispredict is still reported.
- BHT:
  - Index = pc[BHT_IDX+1:2].
  - bht_taken is a combinational read: counter[bht_pc idx][1].
  - Training happens on accept of a conditional branch only: taken → increment, saturating at 11; not-taken → decrement, saturating at 00.
  - Counter writes take effect at the clock edge. A same-cycle lookup of the index being trained returns the old value.
  - JAL/JALR never train.
- Reset mid-operation: an in-flight result is discarded and BHT contents return to 01.

Test Plan:
- BEQ rs1=5, rs2=5, pc=0x100, imm=0x20, pred_taken=0 → next cycle taken=1, target=0x120, mispredict=1, redirect_pc=0x120.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken=1. BLTU with the same operands → taken=0, redirect_pc=pc+4. funct3=010 → taken=0.
- JALR rs1=0x1003, imm=0 → target=0x1002, misalign=1, taken=1, link=pc+4. JALR with pred_target=0x1002, pred_taken=1 → mispredict=0.
- Backpressure: out_ready=0 with out_valid=1 → in_ready=0, outputs stable for 3 cycles; out_ready=1 → accept of the next request in the same cycle. flush with in_valid=1 → out_valid=0 next cycle.
- BHT, pc=0x40: from reset bht_taken=0. After 1 taken branch → counter 10, bht_taken=1. After 3 more taken → saturated at 11. 3 not-taken → 00, and one more not-taken stays 00. A same-cycle lookup during training returns the old value.
- Assert rst_n=0 while out_valid=1 → out_valid=0 immediately (async); BHT lookups return 0 after reset release.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Request/response bundle for the branch resolve unit.
// The master drives requests and consumes results; the slave is the unit itself.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    // Request side
    logic            in_valid;
    logic            in_ready;
    logic            in_is_branch;
    logic            in_is_jal;
    logic            in_is_jalr;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_imm;
    logic            in_pred_taken;
    logic [XLEN-1:0] in_pred_target;

    // Result side
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic [XLEN-1:0] out_target;
    logic [XLEN-1:0] out_link;
    logic            out_mispredict;
    logic [XLEN-1:0] out_redirect_pc;
    logic            out_misalign;

    modport master (
        output in_valid, in_is_branch, in_is_jal, in_is_jalr, in_funct3,
               in_pc, in_rs1, in_rs2, in_imm, in_pred_taken, in_pred_target,
               out_ready,
        input  in_ready, out_valid, out_taken, out_target, out_link,
               out_mispredict, out_redirect_pc, out_misalign
    );

    modport slave (
        input  in_valid, in_is_branch, in_is_jal, in_is_jalr, in_funct3,
               in_pc, in_rs1, in_rs2, in_imm, in_pred_taken, in_pred_target,
               out_ready,
        output in_ready, out_valid, out_taken, out_target, out_link,
               out_mispredict, out_redirect_pc, out_misalign
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: evaluates the branch condition, computes
// target and link, compares against the fetch prediction and registers the
// result behind a valid/ready stage. Also holds the 2-bit BHT that fetch reads
// and that every accepted conditional branch trains.
module branch_resolve_unit #(
    parameter  int XLEN        = 32,
    parameter  int BHT_ENTRIES = 64,
    localparam int BHT_IDX     = $clog2(BHT_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    branch_resolve_unit_if.slave   bus,
    input  logic [XLEN-1:0]        bht_pc,
    output logic                   bht_taken
);

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [XLEN-1:0] C_FOUR    = XLEN'(4);
    localparam logic [XLEN-1:0] C_LSB_CLR = ~XLEN'(1);

    // Combinational resolution of the request currently on the input
    logic            w_accept;
    logic            w_cond;
    logic            w_taken;
    logic            w_is_ctrl;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_pc_imm;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_target;
    logic            w_mispredict;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_misalign;
    logic            w_train;
    logic [BHT_IDX-1:0] w_wr_idx;
    logic [BHT_IDX-1:0] w_rd_idx;
    logic            w_bht_pc_unused;

    // Output stage
    logic            r_valid;
    logic            r_taken;
    logic [XLEN-1:0] r_target;
    logic [XLEN-1:0] r_link;
    logic            r_mispredict;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_misalign;

    // Branch history table
    logic [1:0]      r_bht [BHT_ENTRIES];

    assign bus.in_ready = !r_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;

    assign w_pc4      = bus.in_pc + C_FOUR;
    assign w_pc_imm   = bus.in_pc + bus.in_imm;
    assign w_jalr_sum = bus.in_rs1 + bus.in_imm;

    // Branch condition by funct3; the two reserved encodings resolve not-taken
    always_comb begin
        // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (which would infer a latch).
        w_cond = 1'b0;
        case (bus.in_funct3)
            F3_BEQ:  w_cond = (bus.in_rs1 == bus.in_rs2);
            F3_BNE:  w_cond = (bus.in_rs1 != bus.in_rs2);
            F3_BLT:  w_cond = ($signed(bus.in_rs1) <  $signed(bus.in_rs2));
            F3_BGE:  w_cond = ($signed(bus.in_rs1) >= $signed(bus.in_rs2));
            F3_BLTU: w_cond = (bus.in_rs1 <  bus.in_rs2);
            F3_BGEU: w_cond = (bus.in_rs1 >= bus.in_rs2);
            default: w_cond = 1'b0;
        endcase
    end

    // Direction and target selection by instruction kind
    always_comb begin
        w_taken   = 1'b0;
        w_is_ctrl = 1'b0;
        w_target  = w_pc_imm;
        if (bus.in_is_jalr) begin
            w_taken   = 1'b1;
            w_is_ctrl = 1'b1;
            w_target  = w_jalr_sum & C_LSB_CLR;
        end else if (bus.in_is_jal) begin
            w_taken   = 1'b1;
            w_is_ctrl = 1'b1;
        end else if (bus.in_is_branch) begin
            w_taken   = w_cond;
            w_is_ctrl = 1'b1;
        end
    end

    // A non-control instruction never redirects, whatever fetch predicted
    assign w_mispredict  = w_is_ctrl &&
                           ((w_taken != bus.in_pred_taken) ||
                            (w_taken && (w_target != bus.in_pred_target)));
    assign w_redirect_pc = w_taken ? w_target : w_pc4;
    assign w_misalign    = w_taken && w_target[1];

    // Output register: load on accept, flush wins over a simultaneous accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_taken       <= 1'b0;
            r_target      <= '0;
            r_link        <= '0;
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
            r_misalign    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                r_taken       <= w_taken;
                r_target      <= w_target;
                r_link        <= w_pc4;
                r_mispredict  <= w_mispredict;
                r_redirect_pc <= w_redirect_pc;
                r_misalign    <= w_misalign;
            end
        end
    end

    assign bus.out_valid       = r_valid;
    assign bus.out_taken       = r_taken;
    assign bus.out_target      = r_target;
    assign bus.out_link        = r_link;
    assign bus.out_mispredict  = r_mispredict;
    assign bus.out_redirect_pc = r_redirect_pc;
    assign bus.out_misalign    = r_misalign;

    assign w_train  = w_accept && bus.in_is_branch;
    assign w_wr_idx = bus.in_pc[BHT_IDX+1:2];
    assign w_rd_idx = bht_pc[BHT_IDX+1:2];

    // BHT training: saturating 2-bit counters, written at the clock edge only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table is reset explicitly because prediction must restart from weakly not-taken after every reset.
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_train) begin
            if (w_cond && (r_bht[w_wr_idx] != 2'b11)) begin
                r_bht[w_wr_idx] <= r_bht[w_wr_idx] + 2'b01;
            end else if (!w_cond && (r_bht[w_wr_idx] != 2'b00)) begin
                r_bht[w_wr_idx] <= r_bht[w_wr_idx] - 2'b01;
            end
        end
    end

    // Fetch lookup sees the pre-edge counter, even for the index being trained
    assign bht_taken = r_bht[w_rd_idx][1];

    // Lookup PC bits outside the index field do not select anything
    assign w_bht_pc_unused = ^{bht_pc[XLEN-1:BHT_IDX+2], bht_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: table of hand-computed vectors
// fed through a scoreboard, plus directed sequences for backpressure, flush,
// BHT training and asynchronous reset.
module tb_branch_resolve_unit;

    localparam int XLEN = 32;

    localparam logic [2:0] K_NONE = 3'b000;
    localparam logic [2:0] K_BR   = 3'b100;
    localparam logic [2:0] K_JAL  = 3'b010;
    localparam logic [2:0] K_JALR = 3'b001;

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [2:0]  f3;
        logic [2:0]  kind;
        logic        pt;
        logic [31:0] ptgt;
        logic        e_taken;
        logic [31:0] e_target, e_link;
        logic        e_misp;
        logic [31:0] e_redir;
        logic        e_mis;
        logic        chk_tgt;
    } vec_t;

    logic clk;
    logic rst_n;
    logic flush;
    logic [XLEN-1:0] bht_pc;
    logic bht_taken;

    branch_resolve_unit_if #(.XLEN(XLEN)) bus ();

    branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(64)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus.slave),
        .bht_pc    (bht_pc),
        .bht_taken (bht_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t sb[$];
    vec_t cur;
    vec_t mon_e;
    vec_t tbl[15];
    vec_t v_t, v_n, v_j;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] pc, rs1, rs2, imm, input logic [2:0] f3,
                                input logic [2:0] kind, input logic pt, input logic [31:0] ptgt,
                                input logic et, input logic [31:0] etgt, elink,
                                input logic em, input logic [31:0] eredir, input logic emis);
        vec_t v;
        v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.f3 = f3; v.kind = kind;
        v.pt = pt; v.ptgt = ptgt; v.e_taken = et; v.e_target = etgt; v.e_link = elink;
        v.e_misp = em; v.e_redir = eredir; v.e_mis = emis; v.chk_tgt = 1'b1;
        return v;
    endfunction

    // Put a request on the bus without waiting; caller sits just after a posedge
    task automatic set_in(input vec_t v);
        cur                = v;
        bus.in_pc          = v.pc;
        bus.in_rs1         = v.rs1;
        bus.in_rs2         = v.rs2;
        bus.in_imm         = v.imm;
        bus.in_funct3      = v.f3;
        bus.in_is_branch   = v.kind[2];
        bus.in_is_jal      = v.kind[1];
        bus.in_is_jalr     = v.kind[0];
        bus.in_pred_taken  = v.pt;
        bus.in_pred_target = v.ptgt;
        bus.in_valid       = 1'b1;
    endtask

    // Present a request and return just after the edge that accepted it
    task automatic drive(input vec_t v);
        set_in(v);
        @(negedge clk);
        for (int n = 0; !bus.in_ready; n++) begin
            if (n >= 100) begin
                check("accept_timeout", 64'(bus.in_ready), 64'd1);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_bht(input string name, input logic exp);
        @(negedge clk);
        check(name, 64'(bht_taken), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accept, pop and compare on output handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'(bus.out_valid), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_taken", 64'(bus.out_taken), 64'(mon_e.e_taken));
                    if (mon_e.chk_tgt)
                        check("out_target", 64'(bus.out_target), 64'(mon_e.e_target));
                    check("out_link", 64'(bus.out_link), 64'(mon_e.e_link));
                    check("out_mispredict", 64'(bus.out_mispredict), 64'(mon_e.e_misp));
                    check("out_redirect_pc", 64'(bus.out_redirect_pc), 64'(mon_e.e_redir));
                    check("out_misalign", 64'(bus.out_misalign), 64'(mon_e.e_mis));
                end
            end else if (bus.out_valid && flush && sb.size() > 0) begin
                mon_e = sb.pop_front();
            end
            if (bus.in_valid && bus.in_ready && !flush) sb.push_back(cur);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //            pc            rs1           rs2      imm           f3    kind    pt  ptgt          et  etgt          elink         em  eredir        emis
        tbl[0]  = mk(32'h100,      32'h5,        32'h5,   32'h20,       3'd0, K_BR,   0,  32'h0,        1,  32'h120,      32'h104,      1,  32'h120,      0);
        tbl[1]  = mk(32'h200,      32'hFFFFFFFF, 32'h1,   32'h10,       3'd4, K_BR,   0,  32'h0,        1,  32'h210,      32'h204,      1,  32'h210,      0);
        tbl[2]  = mk(32'h200,      32'hFFFFFFFF, 32'h1,   32'h10,       3'd6, K_BR,   0,  32'h0,        0,  32'h210,      32'h204,      0,  32'h204,      0);
        tbl[3]  = mk(32'h300,      32'h1,        32'h2,   32'h8,        3'd2, K_BR,   0,  32'h0,        0,  32'h308,      32'h304,      0,  32'h304,      0);
        tbl[4]  = mk(32'h400,      32'h1003,     32'h0,   32'h0,        3'd0, K_JALR, 0,  32'h0,        1,  32'h1002,     32'h404,      1,  32'h1002,     1);
        tbl[5]  = mk(32'h400,      32'h1003,     32'h0,   32'h0,        3'd0, K_JALR, 1,  32'h1002,     1,  32'h1002,     32'h404,      0,  32'h1002,     1);
        tbl[6]  = mk(32'h500,      32'h3,        32'h3,   32'h40,       3'd1, K_BR,   1,  32'h540,      0,  32'h540,      32'h504,      1,  32'h504,      0);
        tbl[7]  = mk(32'h600,      32'h80000000, 32'h0,   32'hFFFFFFF0, 3'd5, K_BR,   0,  32'h0,        0,  32'h5F0,      32'h604,      0,  32'h604,      0);
        tbl[8]  = mk(32'h600,      32'h80000000, 32'h0,   32'hFFFFFFF0, 3'd7, K_BR,   1,  32'h5F0,      1,  32'h5F0,      32'h604,      0,  32'h5F0,      0);
        tbl[9]  = mk(32'hFFFFFFFC, 32'h0,        32'h0,   32'h8,        3'd0, K_JAL,  1,  32'h4,        1,  32'h4,        32'h0,        0,  32'h4,        0);
        tbl[10] = mk(32'h700,      32'h0,        32'h0,   32'h0,        3'd0, K_NONE, 1,  32'h800,      0,  32'h0,        32'h704,      0,  32'h704,      0);
        tbl[10].chk_tgt = 1'b0;
        tbl[11] = mk(32'h800,      32'h0,        32'h0,   32'h6,        3'd0, K_JAL,  1,  32'h806,      1,  32'h806,      32'h804,      0,  32'h806,      1);
        tbl[12] = mk(32'h900,      32'h7,        32'h7,   32'h100,      3'd0, K_BR,   1,  32'h904,      1,  32'hA00,      32'h904,      1,  32'hA00,      0);
        tbl[13] = mk(32'hA00,      32'h1,        32'hFFFFFFFF, 32'h4,   3'd4, K_BR,   0,  32'h0,        0,  32'hA04,      32'hA04,      0,  32'hA04,      0);
        tbl[14] = mk(32'hB00,      32'h2000,     32'h0,   32'hFFFFFFFF, 3'd0, K_JALR, 0,  32'h0,        1,  32'h1FFE,     32'hB04,      1,  32'h1FFE,     1);

        // BHT training vectors at pc 0x40 (index 16) and a JAL at the same pc
        v_t = mk(32'h40, 32'h1, 32'h1, 32'h10, 3'd0, K_BR,  1, 32'h50, 1, 32'h50, 32'h44, 0, 32'h50, 0);
        v_n = mk(32'h40, 32'h1, 32'h2, 32'h10, 3'd0, K_BR,  0, 32'h0,  0, 32'h50, 32'h44, 0, 32'h44, 0);
        v_j = mk(32'h40, 32'h0, 32'h0, 32'h8,  3'd0, K_JAL, 1, 32'h48, 1, 32'h48, 32'h44, 0, 32'h48, 0);

        rst_n         = 1'b0;
        flush         = 1'b0;
        bht_pc        = 32'h40;
        bus.out_ready = 1'b1;
        set_in(tbl[0]);
        bus.in_valid  = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_target", 64'(bus.out_target), 64'd0);
        check("rst_out_link", 64'(bus.out_link), 64'd0);
        check("rst_out_redirect", 64'(bus.out_redirect_pc), 64'd0);
        check("rst_bht", 64'(bht_taken), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Table vectors, back-to-back
        for (int i = 0; i < 15; i++) drive(tbl[i]);
        @(negedge clk);
        @(negedge clk);
        check("table_drained", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;

        // BHT training at pc 0x40
        chk_bht("bht_from_reset", 1'b0);
        drive(v_t);
        chk_bht("bht_weak_taken", 1'b1);
        drive(v_t); drive(v_t); drive(v_t);
        chk_bht("bht_saturated_hi", 1'b1);
        drive(v_n);
        chk_bht("bht_dec_from_11", 1'b1);
        drive(v_n);
        chk_bht("bht_dec_to_01", 1'b0);
        drive(v_n); drive(v_n);
        drive(v_t);
        chk_bht("bht_no_underflow", 1'b0);
        drive(v_t);
        chk_bht("bht_back_to_10", 1'b1);
        set_in(v_n);
        @(negedge clk);
        check("bht_same_cycle_old", 64'(bht_taken), 64'd1);
        check("bht_same_cycle_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk_bht("bht_after_train", 1'b0);
        drive(v_j);
        chk_bht("bht_jal_no_train", 1'b0);

        // Backpressure: hold for three cycles, then same-cycle accept on release
        bus.out_ready = 1'b0;
        drive(tbl[0]);
        set_in(tbl[4]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_hold_target", 64'(bus.out_target), 64'(tbl[0].e_target));
            check("bp_hold_redirect", 64'(bus.out_redirect_pc), 64'(tbl[0].e_redir));
            check("bp_hold_misp", 64'(bus.out_mispredict), 64'(tbl[0].e_misp));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_accept", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;

        // Flush with a simultaneous accept: flush wins
        drive(tbl[0]);
        set_in(tbl[1]);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_wins", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Flush of a held result
        bus.out_ready = 1'b0;
        drive(tbl[2]);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_held", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        // Asynchronous reset with a result in flight and a trained BHT
        drive(v_t); drive(v_t);
        chk_bht("bht_pre_reset", 1'b1);
        bus.out_ready = 1'b0;
        drive(v_t);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(bus.out_valid), 64'd0);
        check("rst_async_target", 64'(bus.out_target), 64'd0);
        sb.delete();
        #4;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bht_after_reset", 64'(bht_taken), 64'd0);
        check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
        check("valid_after_reset", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Normal operation after reset
        drive(tbl[12]);
        @(negedge clk);
        @(negedge clk);
        check("final_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
